// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg
//   Shared types and constants for the register-file write arbiter.
//   - DATA_WIDTH / NUM_REGS / SEL_WIDTH : register file geometry
//   - wb_req_t   : one write request {sel, data}; used by source A, source B
//                  and as the FIFO entry
//   - port_in_t  : the arbiter's input port group
//   - port_out_t : the arbiter's output port group
package regfile_write_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int SEL_WIDTH  = $clog2(NUM_REGS);

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic    a_valid;
    wb_req_t a;
    logic    b_valid;
    wb_req_t b;
  } port_in_t;

  typedef struct packed {
    logic                b_ready;
    logic                write_en;
    wb_req_t             write;
    logic [NUM_REGS-1:0] pending;
    logic                stall_a;
    logic                err_a_overrun;
  } port_out_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo
//   Synchronous FIFO of wb_req_t entries buffering long-latency results.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset (empties FIFO)
//     push, push_data : enqueue request (ignored when full)
//     pop             : dequeue request (ignored when empty)
//     head            : oldest entry, valid whenever empty is low
//     count           : registered occupancy, 0..DEPTH
//     full, empty     : derived from the registered count
//   DEPTH must be a power of two so the pointers wrap by plain overflow.
module regfile_wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;

  // Head is read straight from the array so the arbiter can issue it in
  // the same cycle it decides to pop.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Merges the in-order pipeline writeback (source A, no backpressure) and
//   buffered long-latency results (source B, valid/ready into a FIFO) onto
//   the register file's single write port, and publishes a per-register
//   pending bitmap for RAW-hazard stalls in decode.
//   Ports:
//     clk, rst                        : clock, synchronous active-high reset
//     in_a_valid/in_a_sel/in_a_data   : pipeline writeback
//     in_b_valid/in_b_ready/in_b_sel/in_b_data : long-latency handshake
//     out_write_en/sel/data           : registered regfile write command
//     out_pending                     : bit r = FIFO holds a write to reg r
//     out_stall_a, out_err_a_overrun  : starvation guard outputs
//   Optional feature macro: OPT_REGFILE_WB_STARVE_GUARD_EN
//     defined   : B head waiting STARVE_LIMIT cycles forces a pop and
//                 raises out_stall_a; A arriving then is dropped and flagged
//     undefined : out_stall_a / out_err_a_overrun tied low, A always wins
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int B_FIFO_DEPTH = 4
`ifdef OPT_REGFILE_WB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_a_valid,
  input  logic [SEL_WIDTH-1:0]  in_a_sel,
  input  logic [DATA_WIDTH-1:0] in_a_data,
  input  logic                  in_b_valid,
  output logic                  in_b_ready,
  input  logic [SEL_WIDTH-1:0]  in_b_sel,
  input  logic [DATA_WIDTH-1:0] in_b_data,
  output logic                  out_write_en,
  output logic [SEL_WIDTH-1:0]  out_write_sel,
  output logic [DATA_WIDTH-1:0] out_write_data,
  output logic [NUM_REGS-1:0]   out_pending,
  output logic                  out_stall_a,
  output logic                  out_err_a_overrun
);

  localparam int CNT_W = $clog2(B_FIFO_DEPTH) + 1;

  port_in_t   port_in;
  port_out_t  port_out;

  wb_req_t    fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       a_req;
  logic       a_win;
  logic       stall;

  logic                  write_en_reg;
  wb_req_t               write_reg;
  logic [NUM_REGS-1:0]   pending_vec;

  assign port_in.a_valid = in_a_valid;
  assign port_in.a.sel   = in_a_sel;
  assign port_in.a.data  = in_a_data;
  assign port_in.b_valid = in_b_valid;
  assign port_in.b.sel   = in_b_sel;
  assign port_in.b.data  = in_b_data;

  regfile_wb_fifo #(.DEPTH(B_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (port_in.b),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Writes to register 0 are accepted (handshake completes) but never
  // enqueued or issued.
  assign push  = port_in.b_valid && !fifo_full && (port_in.b.sel != '0);
  assign a_req = port_in.a_valid && (port_in.a.sel != '0);
  assign a_win = a_req && !stall;
  // Only the registered occupancy is consulted, so a push is never
  // bypassed to the write port in its own cycle.
  assign pop   = !fifo_empty && (stall || !a_req);

`ifdef OPT_REGFILE_WB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_reg;
  logic                err_reg;

  assign stall = !fifo_empty && (starve_reg == STARVE_W'(STARVE_LIMIT));

  // Never exceeds STARVE_LIMIT: reaching it forces a pop which clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (fifo_empty || pop) starve_reg <= '0;
      else                   starve_reg <= starve_reg + 1'b1;
      if (port_in.a_valid && stall) err_reg <= 1'b1;
    end
  end

  assign port_out.stall_a       = stall;
  assign port_out.err_a_overrun = err_reg;
`else
  assign stall                  = 1'b0;
  assign port_out.stall_a       = 1'b0;
  assign port_out.err_a_overrun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_reg <= 1'b0;
      write_reg    <= '0;
    end else begin
      write_en_reg <= a_win || pop;
      if (a_win)    write_reg <= port_in.a;
      else if (pop) write_reg <= fifo_head;
      else          write_reg <= '0;
    end
  end

  // Per-register count of queued writes; pending is registered from the
  // next-state count so it drops in the same cycle the last write issues.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      logic             push_hit;
      logic             pop_hit;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             pend_reg;

      assign push_hit = push && (port_in.b.sel == SEL_WIDTH'(gi));
      assign pop_hit  = pop && (fifo_head.sel == SEL_WIDTH'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (push_hit && !pop_hit)      cnt_next = cnt_reg + 1'b1;
        else if (pop_hit && !push_hit) cnt_next = cnt_reg - 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          pend_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          pend_reg <= (cnt_next != '0);
        end
      end

      assign pending_vec[gi] = pend_reg;
    end
  endgenerate

  assign port_out.b_ready  = (fifo_count < CNT_W'(B_FIFO_DEPTH));
  assign port_out.write_en = write_en_reg;
  assign port_out.write    = write_reg;
  assign port_out.pending  = pending_vec;

  assign in_b_ready        = port_out.b_ready;
  assign out_write_en      = port_out.write_en;
  assign out_write_sel     = port_out.write.sel;
  assign out_write_data    = port_out.write.data;
  assign out_pending       = port_out.pending;
  assign out_stall_a       = port_out.stall_a;
  assign out_err_a_overrun = port_out.err_a_overrun;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the write arbiter.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_a_valid;
  logic [SEL_WIDTH-1:0]  in_a_sel;
  logic [DATA_WIDTH-1:0] in_a_data;
  logic                  in_b_valid;
  logic                  in_b_ready;
  logic [SEL_WIDTH-1:0]  in_b_sel;
  logic [DATA_WIDTH-1:0] in_b_data;
  logic                  out_write_en;
  logic [SEL_WIDTH-1:0]  out_write_sel;
  logic [DATA_WIDTH-1:0] out_write_data;
  logic [NUM_REGS-1:0]   out_pending;
  logic                  out_stall_a;
  logic                  out_err_a_overrun;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .in_a_valid        (in_a_valid),
    .in_a_sel          (in_a_sel),
    .in_a_data         (in_a_data),
    .in_b_valid        (in_b_valid),
    .in_b_ready        (in_b_ready),
    .in_b_sel          (in_b_sel),
    .in_b_data         (in_b_data),
    .out_write_en      (out_write_en),
    .out_write_sel     (out_write_sel),
    .out_write_data    (out_write_data),
    .out_pending       (out_pending),
    .out_stall_a       (out_stall_a),
    .out_err_a_overrun (out_err_a_overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the B queue in arrival order, the starvation
  // wait counter and the sticky overrun flag.
  logic [SEL_WIDTH-1:0]  q_sel [$];
  logic [DATA_WIDTH-1:0] q_data[$];
  int   starve = 0;
  logic err_m  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance
  // the model, then check the registered outputs after the edge.
  task automatic step(input logic r,
                      input logic av, input logic [SEL_WIDTH-1:0] as, input logic [DATA_WIDTH-1:0] ad,
                      input logic bv, input logic [SEL_WIDTH-1:0] bs, input logic [DATA_WIDTH-1:0] bd);
    logic exp_stall, a_req, b_ok, popm, was_empty, exp_en;
    logic [SEL_WIDTH-1:0]  es;
    logic [DATA_WIDTH-1:0] ed;
    logic [NUM_REGS-1:0]   ep;
    @(negedge clk);
    rst = r; in_a_valid = av; in_a_sel = as; in_a_data = ad;
    in_b_valid = bv; in_b_sel = bs; in_b_data = bd;
    #1;
    check("b_ready", in_b_ready, q_sel.size() < DEPTH);
    exp_stall = 1'b0;
`ifdef OPT_REGFILE_WB_STARVE_GUARD_EN
    exp_stall = (q_sel.size() != 0) && (starve == LIMIT);
`endif
    check("stall_a", out_stall_a, exp_stall);

    exp_en = 1'b0; es = '0; ed = '0;
    if (r) begin
      q_sel.delete(); q_data.delete(); starve = 0; err_m = 1'b0;
    end else begin
      was_empty = (q_sel.size() == 0);
      a_req = av && (as != 0);
      b_ok  = bv && (q_sel.size() < DEPTH) && (bs != 0);
      popm  = !was_empty && (exp_stall || !a_req);
      if (a_req && !exp_stall) begin
        exp_en = 1'b1; es = as; ed = ad;
      end else if (popm) begin
        exp_en = 1'b1; es = q_sel.pop_front(); ed = q_data.pop_front();
      end
      if (exp_stall && av) err_m = 1'b1;
      if (was_empty || popm) starve = 0;
      else                   starve++;
      if (b_ok) begin
        q_sel.push_back(bs); q_data.push_back(bd);
      end
    end
    ep = '0;
    foreach (q_sel[i]) ep[q_sel[i]] = 1'b1;

    @(posedge clk);
    #1;
    check("write_en", out_write_en, exp_en);
    if (exp_en) begin
      check("write_sel", out_write_sel, es);
      check("write_data", out_write_data, ed);
      $display("txn t=%0t write r%0d = %08h", $time, out_write_sel, out_write_data);
    end
    check("pending", out_pending, ep);
    check("err_a_overrun", out_err_a_overrun, err_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_a_valid = 0; in_a_sel = 0; in_a_data = 0;
    in_b_valid = 0; in_b_sel = 0; in_b_data = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset then idle
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // A only: r3 = DEADBEEF, one-cycle latency, single-cycle pulse
    step(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
    idle(2);

    // B only: r5 = 0x11, pending then two-cycle write
    step(0, 0, 0, 0, 1, 4'd5, 32'h11);
    idle(3);

    // Fill the FIFO under continuous A traffic, fifth offer is refused
    step(0, 1, 4'd1, 32'hA0, 1, 4'd2, 32'hB0);
    step(0, 1, 4'd1, 32'hA1, 1, 4'd4, 32'hB1);
    step(0, 1, 4'd1, 32'hA2, 1, 4'd6, 32'hB2);
    step(0, 1, 4'd1, 32'hA3, 1, 4'd7, 32'hB3);
    step(0, 1, 4'd1, 32'hA4, 1, 4'd8, 32'hB4);
    step(0, 1, 4'd1, 32'hA5, 0, 0, 0);
    idle(6);

    // Register 0 on both sources is swallowed
    step(0, 1, 4'd0, 32'h1234, 1, 4'd0, 32'h5678);
    idle(2);

    // Same register queued twice, then reset mid-operation discards it
    step(0, 1, 4'd1, 32'hC0, 1, 4'd9, 32'hD0);
    step(0, 1, 4'd2, 32'hC1, 1, 4'd9, 32'hD1);
    step(0, 1, 4'd3, 32'hC2, 1, 4'd10, 32'hD2);
    step(1, 1, 4'd4, 32'hC3, 1, 4'd11, 32'hD3);
    idle(3);

`ifdef OPT_REGFILE_WB_STARVE_GUARD_EN
    // Starvation guard: A held valid with one B entry waiting
    step(0, 1, 4'd1, 32'hE0, 1, 4'd12, 32'hF0);
    for (int i = 0; i < 12; i++) step(0, 1, 4'd1, 32'hE1 + i, 0, 0, 0);
    idle(2);
`endif

    // Randomized traffic with varying A/B intensity
    for (int blk = 0; blk < 40; blk++) begin
      int pa, pb;
      pa = $urandom_range(0, 100);
      pb = $urandom_range(0, 100);
      for (int c = 0; c < 50; c++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < pa), 4'($urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 99) < pb), 4'($urandom_range(0, 15)), $urandom);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sits directly upstream of the register file's single synchronous write port.
- Merges two result sources onto that port:
  - source A: the in-order pipeline writeback, with no backpressure;
  - source B: long-latency results (mul/div/load), using a valid/ready handshake and buffered in a FIFO.
- Produces a registered write command plus a per-register pending bitmap, which decode uses for RAW-hazard stalls.

Parameters:
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 16, register count; select width is SEL_WIDTH = clog2(NUM_REGS) = 4.
- B_FIFO_DEPTH, 4, source-B buffer entries; must be a power of two and at least 2.
- STARVE_LIMIT, 8, cycles the B head may wait before a stall request; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_a_valid  in  1  pipeline writeback valid
- in_a_sel  in  4  destination register
- in_a_data  in  32  result
- in_b_valid  in  1  long-latency result valid
- in_b_ready  out  1  FIFO can accept
- in_b_sel  in  4  destination register
- in_b_data  in  32  result
- out_write_en  out  1  to regfile write_en
- out_write_sel  out  4  to regfile write_sel
- out_write_data  out  32  to regfile write_data
- out_pending  out  16  bit r set = FIFO holds an unissued write to register r
- out_stall_a  out  1  (optional feature only) upstream must hold in_a_valid low this cycle
- out_err_a_overrun  out  1  (optional feature only) sticky violation flag

Behaviour:
- Reset (rst high at posedge):
  - FIFO emptied; pending counters cleared.
  - out_write_en/sel/data = 0, out_pending = 0, out_stall_a = 0, out_err_a_overrun = 0.
  - in_b_ready = 1 from the cycle after reset.
  - Reset mid-operation discards all buffered B results with no write issued.
- B handshake:
  - Transfer when in_b_valid && in_b_ready.
  - in_b_ready = (count < B_FIFO_DEPTH), registered-count based; a same-cycle pop does not raise ready.
- Register 0:
  - A or B transfers with sel == 0 are accepted and dropped.
  - They are never enqueued, never set pending, and never produce out_write_en.
- Arbitration each cycle t:
  - If in_a_valid && in_a_sel != 0, A wins.
  - Else if the FIFO is non-empty, pop the head.
  - The winner appears on out_write_* at t+1, registered, for exactly one cycle.
  - out_write_en is 0 when there is no winner.
- Latency:
  - A: 1 cycle.
  - B: minimum 2 cycles (enqueue at t, earliest pop at t+1, write visible at t+2).
- Ordering: B entries issue strictly FIFO; A and B are unordered relative to each other.
  - Decode guarantees no A write targets a register with its pending bit set.
- Pending tracking:
  - Per-register counter, width clog2(B_FIFO_DEPTH)+1.
  - Increments on enqueue and decrements on pop.
  - Same-register simultaneous push and pop leaves the count unchanged.
  - out_pending[r] = (cnt[r] != 0), registered; it clears in the same cycle out_write_en for the last entry asserts.
- Boundaries:
  - Full FIFO: ready low, no push.
  - Empty FIFO with B arriving at t: push at t, no bypass.
  - Pointers wrap modulo B_FIFO_DEPTH.
  - Continuous A traffic may starve B indefinitely unless the optional feature is compiled in.

Optional Feature:
- Macro: OPT_REGFILE_WB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the FIFO is non-empty and no pop occurs; it resets on pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, out_stall_a is driven high combinationally; the B head is popped that cycle regardless of A.
  - If in_a_valid is high while out_stall_a is high, A is dropped and out_err_a_overrun sets (sticky until rst).
- Undefined: out_stall_a and out_err_a_overrun are tied 0 and the counter is absent.

Decomposition:
- PkgRegfileWriteArbiter holds:
  - constants DATA_WIDTH, NUM_REGS, SEL_WIDTH;
  - packed struct WbReq {sel, data} shared by both sources and the FIFO entry;
  - PortIn/PortOut structs matching the port groups.
- One sub-module, regfile_wb_fifo: a synchronous FIFO of WbReq with push/pop/count/full/empty.
- Arbitration and pending counters live in the top module.

Test Plan:
- Reset then idle: out_write_en = 0, out_pending = 0, in_b_ready = 1.
- A only, sel = 3, data = 0xDEADBEEF at t: out_write_en = 1, sel = 3, data = 0xDEADBEEF at t+1, then 0 at t+2.
- B to r5 = 0x11 with A idle: pending[5] = 1 at t+1; write r5 = 0x11 at t+2; pending[5] = 0 at t+2.
- Fill FIFO with 4 B results under continuous A traffic: in_b_ready falls after the 4th push. After A stops, 4 writes issue in push order on consecutive cycles. Ready returns 1 the cycle after the first pop.
- sel = 0 on A and on B: no write issued, no pending bit set, FIFO count unchanged.
- Guard enabled, STARVE_LIMIT = 8, A held valid with one B entry:
  - out_stall_a rises 8 cycles after the enqueue and the B write issues;
  - A held valid during the stall sets out_err_a_overrun.
